qf_soc_top: RTL and testbench
=============================

// Module: qf_soc_top
// PURPOSE
//  Top-level RV32I microcontroller: one RV32I core, a 16 KiB instruction TCM (ITCM) and
//  a 16 KiB data TCM (DTCM). No external I/O besides clock and reset; programs are
//  backdoor-loaded into ITCM and results read from the core register file.
//  Single-cycle core: every instruction fetches, executes and retires in one clk.
// PARAMETERS
//  ITCM_AW   12            ITCM word-address width (4096 x 32-bit words)
//  DTCM_AW   12            DTCM word-address width (4096 x 32-bit words)
//  RESET_PC  32'h0000_0000 PC after reset
//  DTCM_BASE 32'h1000_0000 DTCM base; address bit 28 selects DTCM, else ITCM
// PORTS
//  clk    in  1  system clock, all state on rising edge
//  rst_n  in  1  asynchronous active-low reset
// BEHAVIOUR
//  - Reset (async assert, sync release on clk): PC=RESET_PC, x0..x31=0. Memories not reset.
//  - ISA: RV32I base: LUI AUIPC JAL JALR BRANCH LOAD STORE OP-IMM OP. FENCE, ECALL,
//    EBREAK, SYSTEM/CSR and any undecoded opcode retire as NOP (PC+4, no writes).
//  - Fetch: combinational ITCM read at mem[PC[ITCM_AW+1:2]]; PC[1:0] ignored.
//  - Per clk: regfile write (rd!=0) and PC update occur together; x0 always reads 0.
//  - Next PC: branch taken / JAL -> PC+imm; JALR -> (rs1+imm)&~1; else PC+4. JAL/JALR
//    write PC+4 to rd. Misaligned targets not trapped (low bits dropped at fetch).
//  - Branches: BEQ BNE BLT BGE signed, BLTU BGEU unsigned.
//  - ALU: ADD SUB SLL SRL SRA SLT SLTU XOR OR AND; shift amount = operand[4:0];
//    arithmetic mod 2^32, no overflow flag.
//  - Loads: combinational read, result written same cycle. LB/LH sign-extend, LBU/LHU
//    zero-extend, LW; byte lane from addr[1:0]. Misaligned H/W: use addr[1] / word
//    aligned (low bits dropped), no trap.
//  - Data address decode: addr[28]=1 -> DTCM; else ITCM (loads allowed, stores ignored).
//    Index = addr[AW+1:2] (wraps within TCM).
//  - Stores (SB/SH/SW): DTCM written on rising clk with 4-bit byte enables; read-during-
//    write returns old data within the same cycle.
//  - Mid-run reset: PC and registers return to reset values; TCM contents preserved.
// STRUCTURE
//  - Package qf_rv_pkg: opcode/funct3/funct7 constants, ALU-op enum, memory-map params.
//  - Fixed hierarchy (benches use backdoor paths):
//    u_itcm: TCM, array 'mem' [0:2**ITCM_AW-1] of 32-bit, little-endian bytes;
//    u_dtcm: same shape, array 'mem';
//    core: RV32I datapath with sub-module instance u_regfiles holding 'regs' [0:31] x 32-bit.
//  - One shared TCM module (byte-enable write port, async read) used for both ITCM/DTCM.
// TESTING (clk period 20 ns, rst_n released before first rising edge)
//  - ALU: li ra,50; li sp,55; add gp,sp,ra; sub tp,sp,ra -> x3=105, x4=5 after 4 clks.
//  - Memory: lui a5,0x10000; li a4,-1; sb a4,1(a5); lbu t0,1(a5); lh t1,0(a5)
//    -> DTCM word0=0x0000_FF00, t0=0xFF, t1=0xFFFF_FF00.
//  - Branch/jump: li ra,1; li sp,1; beq ra,sp,+0x58 -> next PC 0x64, skipped
//    instructions leave regs untouched; jal ra,+8 at 0x64 -> ra=0x68, PC=0x6C.
//  - Back-to-back dependency: lb sp,0(a5); addi tp,sp,1 with byte 0x7F -> tp=0x80.
//  - Compliance: rv32ui riscv-tests images loaded at 0; program sets x26=1 on
//    completion, x27=1 on pass, x3=failing test number; every test must
//    reach x26=1 within 2500 clks with x27=1.
//  - Reset: assert rst_n mid-program -> PC=0 and all regs 0 immediately; program reruns.

Source files
------------

// File: rtl/qf_rv_pkg.sv
// Shared RV32I encodings, ALU operation set and memory-map defaults
// for the qf_soc_top microcontroller.
package qf_rv_pkg;

  localparam int          QF_ITCM_AW   = 12;
  localparam int          QF_DTCM_AW   = 12;
  localparam logic [31:0] QF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] QF_DTCM_BASE = 32'h1000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MB  = 3'b000;
  localparam logic [2:0] F3_MH  = 3'b001;
  localparam logic [2:0] F3_MW  = 3'b010;
  localparam logic [2:0] F3_MBU = 3'b100;
  localparam logic [2:0] F3_MHU = 3'b101;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB / SRA variants (instr bit 30 where it is meaningful)
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/qf_soc_top_core.sv
// Single-cycle RV32I datapath: fetch, decode, execute, memory access and
// writeback all complete within one clock.
module qf_soc_top_core
  import qf_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = QF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata
);

  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, alu_b, alu_y, load_val, byte_sh;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        rd_we;
  logic [31:0] rd_data;
  alu_op_e     alu_op;

  assign instr     = imem_rdata;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  qf_soc_top_regfile u_regfiles (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rd_we),
    .rd_addr  (rd),
    .rd_data  (rd_data)
  );

  // bit 30 is an immediate bit for OP-IMM except on shifts-right
  always_comb begin
    alu_b  = (opcode == OP_OP) ? rs2_data : imm_i;
    alu_op = alu_decode(funct3, instr[30] && (opcode == OP_OP || funct3 == F3_SR));
  end

  assign alu_y     = alu_exec(alu_op, rs1_data, alu_b);
  assign dmem_addr = rs1_data + ((opcode == OP_STORE) ? imm_s : imm_i);

  always_comb begin
    byte_sh   = dmem_rdata >> {dmem_addr[1:0], 3'b000};
    lane_byte = byte_sh[7:0];
    lane_half = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      F3_MB:   load_val = {{24{lane_byte[7]}}, lane_byte};
      F3_MBU:  load_val = {24'b0, lane_byte};
      F3_MH:   load_val = {{16{lane_half[15]}}, lane_half};
      F3_MHU:  load_val = {16'b0, lane_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    pc_d       = pc_plus4;
    rd_we      = 1'b0;
    rd_data    = alu_y;
    dmem_be    = 4'b0000;
    dmem_wdata = rs2_data;
    case (opcode)
      OP_LUI: begin
        rd_we   = 1'b1;
        rd_data = imm_u;
      end
      OP_AUIPC: begin
        rd_we   = 1'b1;
        rd_data = pc_q + imm_u;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_data = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      OP_JALR: begin
        rd_we   = 1'b1;
        rd_data = pc_plus4;
        pc_d    = (rs1_data + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (branch_taken(funct3, rs1_data, rs2_data)) pc_d = pc_q + imm_b;
      end
      OP_LOAD: begin
        rd_we   = 1'b1;
        rd_data = load_val;
      end
      OP_STORE: begin
        case (funct3)
          F3_MB: begin
            dmem_be    = 4'b0001 << dmem_addr[1:0];
            dmem_wdata = {4{rs2_data[7:0]}};
          end
          F3_MH: begin
            dmem_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{rs2_data[15:0]}};
          end
          F3_MW:   dmem_be = 4'b1111;
          default: dmem_be = 4'b0000;
        endcase
      end
      OP_IMM, OP_OP: rd_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/qf_soc_top_regfile.sv
// 32 x 32-bit integer register file, two async read ports, one write port.
// x0 is hardwired to zero on read and never written.
module qf_soc_top_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/qf_soc_top_tcm.sv
// Tightly-coupled memory: one byte-enabled synchronous write port and
// NR asynchronous read ports. Contents are never reset.
module qf_soc_top_tcm #(
  parameter int AW = 12,
  parameter int NR = 1
) (
  input  logic                   clk,
  input  logic [3:0]             we,
  input  logic [AW-1:0]          waddr,
  input  logic [31:0]            wdata,
  input  logic [NR-1:0][AW-1:0]  raddr,
  output logic [NR-1:0][31:0]    rdata
);

  logic [31:0] mem [0:2**AW-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign rdata[r] = mem[raddr[r]];
  end

endmodule

// File: rtl/qf_soc_top.sv
// RV32I microcontroller top: single-cycle core plus ITCM and DTCM.
// Data accesses with the DTCM base bit set go to DTCM, all others to ITCM (read-only).
module qf_soc_top
  import qf_rv_pkg::*;
#(
  parameter int          ITCM_AW   = QF_ITCM_AW,
  parameter int          DTCM_AW   = QF_DTCM_AW,
  parameter logic [31:0] RESET_PC  = QF_RESET_PC,
  parameter logic [31:0] DTCM_BASE = QF_DTCM_BASE
) (
  input logic clk,
  input logic rst_n
);

  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, dmem_wdata;
  logic [3:0]  dmem_be, dtcm_we;
  logic        dtcm_sel;

  logic [1:0][ITCM_AW-1:0] itcm_raddr;
  logic [1:0][31:0]        itcm_rdata;
  logic [0:0][DTCM_AW-1:0] dtcm_raddr;
  logic [0:0][31:0]        dtcm_rdata;

  qf_soc_top_core #(.RESET_PC(RESET_PC)) core (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata)
  );

  assign dtcm_sel   = |(dmem_addr & DTCM_BASE);
  assign dtcm_we    = dtcm_sel ? dmem_be : 4'b0000;
  assign itcm_raddr = {dmem_addr[ITCM_AW+1:2], imem_addr[ITCM_AW+1:2]};
  assign dtcm_raddr = dmem_addr[DTCM_AW+1:2];
  assign imem_rdata = itcm_rdata[0];
  assign dmem_rdata = dtcm_sel ? dtcm_rdata[0] : itcm_rdata[1];

  // port 0 is instruction fetch, port 1 serves data loads from ITCM
  qf_soc_top_tcm #(.AW(ITCM_AW), .NR(2)) u_itcm (
    .clk   (clk),
    .we    (4'b0000),
    .waddr ('0),
    .wdata ('0),
    .raddr (itcm_raddr),
    .rdata (itcm_rdata)
  );

  qf_soc_top_tcm #(.AW(DTCM_AW), .NR(1)) u_dtcm (
    .clk   (clk),
    .we    (dtcm_we),
    .waddr (dmem_addr[DTCM_AW+1:2]),
    .wdata (dmem_wdata),
    .raddr (dtcm_raddr),
    .rdata (dtcm_rdata)
  );

endmodule

// File: tb/tb_qf_soc_top.sv
// Program-level bench for qf_soc_top: tiny hand-assembled programs are
// backdoor-loaded, run for a fixed number of clocks and checked via a scoreboard.
module tb_qf_soc_top;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #10 clk = ~clk;

  qf_soc_top dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum int {SRC_REG, SRC_PC, SRC_DTCM, SRC_ITCM} src_e;
  typedef struct {
    string       name;
    src_e        src;
    int          idx;
    logic [31:0] exp;
  } sb_entry_t;

  typedef struct {
    string       name;
    logic        is_br;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  sb_entry_t   sb_q[$];
  vec_t        vecs[$];
  logic [31:0] prog [0:127];
  logic [31:0] dtcm_init [0:3];
  int          wp;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] read_actual(input src_e s, input int idx);
    case (s)
      SRC_REG:  return dut.core.u_regfiles.regs[idx];
      SRC_PC:   return dut.core.pc_q;
      SRC_DTCM: return dut.u_dtcm.mem[idx];
      default:  return dut.u_itcm.mem[idx];
    endcase
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) prog[i] = NOP;
    for (int i = 0; i < 4; i++) dtcm_init[i] = 32'h0;
    wp = 0;
  endtask

  task automatic emit(input logic [31:0] ins);
    prog[wp] = ins;
    wp++;
  endtask

  task automatic li(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = (v + 32'h800) >> 12;
    emit(enc_u(hi[19:0], rd, 7'b0110111));
    emit(addi(rd, rd, v[11:0]));
  endtask

  task automatic expect_val(input string name, input src_e s, input int idx,
                            input logic [31:0] exp);
    sb_q.push_back('{name, s, idx, exp});
  endtask

  task automatic checkOutput();
    sb_entry_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = read_actual(e.src, e.idx);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("[TB] FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end
    end
  endtask

  // hold reset while memories are preloaded, release on a falling edge
  task automatic applyStimulus(input int ncyc);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 128; i++) dut.u_itcm.mem[i] = prog[i];
    for (int i = 0; i < 4; i++) dut.u_dtcm.mem[i] = dtcm_init[i];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic run_more(input int ncyc);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    vecs.push_back('{"add",    1'b0, 7'h00, 3'd0, 32'd50,        32'd55,        32'd105});
    vecs.push_back('{"sub",    1'b0, 7'h20, 3'd0, 32'd55,        32'd50,        32'd5});
    vecs.push_back('{"sub_neg",1'b0, 7'h20, 3'd0, 32'd0,         32'd1,         32'hFFFF_FFFF});
    vecs.push_back('{"add_wrap",1'b0,7'h00, 3'd0, 32'hFFFF_FFFF, 32'd1,         32'h0});
    vecs.push_back('{"sll",    1'b0, 7'h00, 3'd1, 32'd1,         32'd35,        32'd8});
    vecs.push_back('{"srl",    1'b0, 7'h00, 3'd5, 32'h8000_0000, 32'd31,        32'd1});
    vecs.push_back('{"sra",    1'b0, 7'h20, 3'd5, 32'h8000_0000, 32'd4,         32'hF800_0000});
    vecs.push_back('{"slt",    1'b0, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1,         32'd1});
    vecs.push_back('{"sltu",   1'b0, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0});
    vecs.push_back('{"xor",    1'b0, 7'h00, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
    vecs.push_back('{"or",     1'b0, 7'h00, 3'd6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678});
    vecs.push_back('{"and",    1'b0, 7'h00, 3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000});
    vecs.push_back('{"beq_t",  1'b1, 7'h00, 3'd0, 32'd5,         32'd5,         32'd0});
    vecs.push_back('{"bne_nt", 1'b1, 7'h00, 3'd1, 32'd5,         32'd5,         32'd1});
    vecs.push_back('{"blt_t",  1'b1, 7'h00, 3'd4, 32'hFFFF_FFFF, 32'd1,         32'd0});
    vecs.push_back('{"bge_eq", 1'b1, 7'h00, 3'd5, 32'd1,         32'd1,         32'd0});
    vecs.push_back('{"bge_nt", 1'b1, 7'h00, 3'd5, 32'hFFFF_FFFF, 32'd1,         32'd1});
    vecs.push_back('{"bltu_nt",1'b1, 7'h00, 3'd6, 32'hFFFF_FFFF, 32'd1,         32'd1});
    vecs.push_back('{"bgeu_t", 1'b1, 7'h00, 3'd7, 32'h8000_0000, 32'd1,         32'd0});

    // reset state before any clock edge
    #2 rst_n = 1'b0;
    #1;
    expect_val("rst_pc", SRC_PC, 0, 32'h0);
    expect_val("rst_x1", SRC_REG, 1, 32'h0);
    expect_val("rst_x31", SRC_REG, 31, 32'h0);
    checkOutput();

    // x1=a, x2=b, op at 0x10, slot at 0x14 is skipped only by a taken branch
    for (int k = 0; k < vecs.size(); k++) begin
      clear_prog();
      li(5'd1, vecs[k].a);
      li(5'd2, vecs[k].b);
      if (vecs[k].is_br) begin
        emit(enc_b(13'd8, 5'd2, 5'd1, vecs[k].f3));
        emit(addi(5'd3, 5'd0, 12'd1));
      end else begin
        emit(enc_r(vecs[k].f7, 5'd2, 5'd1, vecs[k].f3, 5'd3));
        emit(NOP);
      end
      expect_val(vecs[k].name, SRC_REG, 3, vecs[k].exp);
      applyStimulus(6);
    end

    $display("[TB] memory sequence");
    clear_prog();
    emit(enc_u(20'h10000, 5'd15, 7'b0110111));
    emit(addi(5'd14, 5'd0, 12'hFFF));
    emit(enc_s(12'd1, 5'd14, 5'd15, 3'b000));
    emit(enc_i(12'd1, 5'd15, 3'b100, 5'd5, 7'b0000011));
    emit(enc_i(12'd0, 5'd15, 3'b001, 5'd6, 7'b0000011));
    emit(enc_s(12'd4, 5'd14, 5'd15, 3'b010));
    emit(enc_s(12'h100, 5'd14, 5'd0, 3'b010));
    emit(enc_i(12'd4, 5'd15, 3'b010, 5'd7, 7'b0000011));
    emit(enc_i(12'h100, 5'd0, 3'b010, 5'd8, 7'b0000011));
    emit(enc_i(12'd0, 5'd15, 3'b101, 5'd10, 7'b0000011));
    expect_val("sb_dtcm0", SRC_DTCM, 0, 32'h0000_FF00);
    expect_val("lbu_t0", SRC_REG, 5, 32'h0000_00FF);
    expect_val("lh_t1", SRC_REG, 6, 32'hFFFF_FF00);
    expect_val("sw_dtcm1", SRC_DTCM, 1, 32'hFFFF_FFFF);
    expect_val("itcm_store_ignored", SRC_ITCM, 64, NOP);
    expect_val("lw_dtcm", SRC_REG, 7, 32'hFFFF_FFFF);
    expect_val("lw_itcm", SRC_REG, 8, NOP);
    expect_val("lhu", SRC_REG, 10, 32'h0000_FF00);
    applyStimulus(10);

    $display("[TB] branch and jump sequence");
    clear_prog();
    emit(addi(5'd1, 5'd0, 12'd1));
    emit(addi(5'd2, 5'd0, 12'd1));
    emit(NOP);
    emit(enc_b(13'h58, 5'd2, 5'd1, 3'b000));
    for (int i = 4; i < 25; i++) prog[i] = addi(5'd7, 5'd0, 12'h7FF);
    prog[25] = enc_j(21'd8, 5'd1);
    prog[26] = addi(5'd8, 5'd0, 12'd5);
    prog[27] = addi(5'd9, 5'd0, 12'd9);
    expect_val("beq_pc", SRC_PC, 0, 32'h0000_0064);
    applyStimulus(4);
    expect_val("jal_ra", SRC_REG, 1, 32'h0000_0068);
    expect_val("jal_pc", SRC_PC, 0, 32'h0000_006C);
    run_more(1);
    expect_val("jal_target", SRC_REG, 9, 32'd9);
    expect_val("jal_skip", SRC_REG, 8, 32'd0);
    expect_val("beq_skip", SRC_REG, 7, 32'd0);
    run_more(1);

    $display("[TB] jalr auipc x0 sequence");
    clear_prog();
    emit(addi(5'd5, 5'd0, 12'h040));
    emit(enc_i(12'h021, 5'd5, 3'b000, 5'd6, 7'b1100111));
    prog[24] = enc_u(20'd1, 5'd7, 7'b0010111);
    prog[25] = addi(5'd0, 5'd0, 12'd5);
    prog[26] = addi(5'd11, 5'd0, 12'd3);
    prog[27] = enc_r(7'h00, 5'd11, 5'd0, 3'd0, 5'd10);
    expect_val("jalr_pc", SRC_PC, 0, 32'h0000_0060);
    expect_val("jalr_link", SRC_REG, 6, 32'h0000_0008);
    applyStimulus(2);
    expect_val("auipc", SRC_REG, 7, 32'h0000_1060);
    expect_val("x0_zero", SRC_REG, 0, 32'h0);
    expect_val("x0_read", SRC_REG, 10, 32'd3);
    run_more(4);

    $display("[TB] load-use sequence");
    clear_prog();
    dtcm_init[0] = 32'h0000_807F;
    emit(enc_u(20'h10000, 5'd15, 7'b0110111));
    emit(enc_i(12'd0, 5'd15, 3'b000, 5'd2, 7'b0000011));
    emit(addi(5'd4, 5'd2, 12'd1));
    emit(enc_i(12'd1, 5'd15, 3'b000, 5'd3, 7'b0000011));
    expect_val("lb_pos", SRC_REG, 2, 32'h0000_007F);
    expect_val("load_use", SRC_REG, 4, 32'h0000_0080);
    expect_val("lb_neg", SRC_REG, 3, 32'hFFFF_FF80);
    applyStimulus(4);

    $display("[TB] mid-run reset sequence");
    clear_prog();
    emit(addi(5'd1, 5'd1, 12'd1));
    emit(enc_j(21'h1FFFFC, 5'd0));
    expect_val("loop_count", SRC_REG, 1, 32'd5);
    applyStimulus(10);
    #3 rst_n = 1'b0;
    #1;
    expect_val("midrst_pc", SRC_PC, 0, 32'h0);
    expect_val("midrst_x1", SRC_REG, 1, 32'h0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    expect_val("rerun_x1", SRC_REG, 1, 32'd2);
    expect_val("rerun_pc", SRC_PC, 0, 32'h0);
    expect_val("itcm_kept", SRC_ITCM, 0, addi(5'd1, 5'd1, 12'd1));
    run_more(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
